// File: rtl/bus_select_pkg.sv
// -----------------------------------------------------------------------------
// bus_select_pkg
//
// Shared definitions for the 8088 bus-select / wait-state generator:
//   - bus_state_t : bus-cycle FSM states (IDLE, ADDR, WAIT, DONE)
//   - WAIT_W      : width of one per-region wait-state field
//   - get_field() : extracts field idx of a given width from a packed
//                   parameter vector (region 0 in the LSBs)
// -----------------------------------------------------------------------------
package bus_select_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    localparam int WAIT_W = 4;

    // Packed parameter vectors are zero-extended to FIELD_VEC_W before being
    // handed to get_field(); a single field may be up to FIELD_MAX_W bits.
    localparam int FIELD_VEC_W = 512;
    localparam int FIELD_MAX_W = 32;

    // Returns bits [idx*width +: width] of vec, zero-extended to FIELD_MAX_W.
    // Intended for elaboration-time use on parameter vectors.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [FIELD_VEC_W-1:0] vec,
        input int                     idx,
        input int                     width
    );
        logic [FIELD_VEC_W-1:0] shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = {FIELD_MAX_W{1'b1}} >> (FIELD_MAX_W - width);
        return shifted[FIELD_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/region_cmp.sv
// -----------------------------------------------------------------------------
// region_cmp
//
// Base/limit comparator for one decoded region. A region matches when the
// cycle type (IO or memory) equals IS_IO and the effective address lies in
// [BASE, LIMIT] inclusive, compared unsigned. For IO regions only the low
// IO_W address bits take part; the upper bits are treated as zero.
//
// Ports:
//   addr  : in  [ADDR_W-1:0] address to test
//   iom   : in               1 = IO cycle, 0 = memory cycle
//   match : out              address falls in this region
// -----------------------------------------------------------------------------
module region_cmp #(
    parameter int                ADDR_W = 20,
    parameter int                IO_W   = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] LIMIT  = '0,
    parameter logic              IS_IO  = 1'b0
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              iom,
    output logic              match
);

    localparam logic [ADDR_W-1:0] IO_MASK = {ADDR_W{1'b1}} >> (ADDR_W - IO_W);
    localparam logic [ADDR_W-1:0] SPAN    = LIMIT - BASE;

    logic [ADDR_W-1:0] addr_eff;
    logic [ADDR_W-1:0] offset;

    assign addr_eff = IS_IO ? (addr & IO_MASK) : addr;

    // One subtract-and-compare instead of two compares: an address below
    // BASE wraps to a value larger than any legal span, so it fails the test.
    assign offset = addr_eff - BASE;
    assign match  = (iom == IS_IO) && (offset <= SPAN);

endmodule

// File: rtl/bus_select_waitgen.sv
// -----------------------------------------------------------------------------
// bus_select_waitgen
//
// Address latch, region decode and wait-state generator for the 8088 bus
// model. The multiplexed address is sampled on ALE and decoded against NREG
// memory/IO regions into a registered one-hot chip select. A per-region
// wait-state counter holds READY low so slow peripherals stretch the cycle.
// An access to an unmapped address pulses decode_err and completes with no
// wait states, so the bus never hangs.
//
// Ports:
//   CLK        : in               clock, single domain
//   RESET      : in               synchronous, active-high reset
//   ALE        : in               address latch enable (edge sampled)
//   IOM        : in               1 = IO cycle, 0 = memory cycle
//   AddrIn     : in  [ADDR_W-1:0] {A, AD} address from the bus
//   RD_N       : in               read strobe, active low
//   WR_N       : in               write strobe, active low
//   Address    : out [ADDR_W-1:0] latched address
//   cs         : out [NREG-1:0]   registered one-hot chip select
//   READY      : out              0 inserts a wait state
//   decode_err : out              one-cycle pulse on a strobe to an unmapped
//                                 address
// -----------------------------------------------------------------------------
module bus_select_waitgen
    import bus_select_pkg::*;
#(
    parameter int                       NREG         = 4,
    parameter int                       ADDR_W       = 20,
    parameter int                       IO_W         = 16,
    parameter logic [NREG*ADDR_W-1:0]   REGION_BASE  = {20'h1C00, 20'hFF00, 20'h80000, 20'h00000},
    parameter logic [NREG*ADDR_W-1:0]   REGION_LIMIT = {20'h1DFF, 20'hFF0F, 20'hFFFFF, 20'h7FFFF},
    parameter logic [NREG-1:0]          REGION_IS_IO = 4'b1100,
    parameter logic [NREG*WAIT_W-1:0]   REGION_WAIT  = {4'd3, 4'd1, 4'd2, 4'd0}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALE,
    input  logic              IOM,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic              RD_N,
    input  logic              WR_N,
    output logic [ADDR_W-1:0] Address,
    output logic [NREG-1:0]   cs,
    output logic              READY,
    output logic              decode_err
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [FIELD_VEC_W-1:0] BASE_VEC  = FIELD_VEC_W'(REGION_BASE);
    localparam logic [FIELD_VEC_W-1:0] LIMIT_VEC = FIELD_VEC_W'(REGION_LIMIT);
    localparam logic [FIELD_VEC_W-1:0] WAIT_VEC  = FIELD_VEC_W'(REGION_WAIT);

    // ------------------------------------------------------------------
    // Region comparators. They look at the incoming AddrIn/IOM so that the
    // chip select can be registered on the same edge that latches the
    // address; cs is then valid right after the ALE edge.
    // ------------------------------------------------------------------
    logic [NREG-1:0]   match;
    logic [WAIT_W-1:0] wait_tab [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_region
        localparam logic [FIELD_MAX_W-1:0] BASE_F  = get_field(BASE_VEC,  i, ADDR_W);
        localparam logic [FIELD_MAX_W-1:0] LIMIT_F = get_field(LIMIT_VEC, i, ADDR_W);
        localparam logic [FIELD_MAX_W-1:0] WAIT_F  = get_field(WAIT_VEC,  i, WAIT_W);

        if (BASE_F > LIMIT_F) begin : g_bad_region
            $error("bus_select_waitgen: region %0d has BASE above LIMIT", i);
        end

        region_cmp #(
            .ADDR_W (ADDR_W),
            .IO_W   (IO_W),
            .BASE   (BASE_F[ADDR_W-1:0]),
            .LIMIT  (LIMIT_F[ADDR_W-1:0]),
            .IS_IO  (REGION_IS_IO[i])
        ) u_region_cmp (
            .addr  (AddrIn),
            .iom   (IOM),
            .match (match[i])
        );

        assign wait_tab[i] = WAIT_F[WAIT_W-1:0];
    end

    // ------------------------------------------------------------------
    // Priority encoder: lowest matching index wins on overlap.
    // ------------------------------------------------------------------
    logic [NREG-1:0]   dec_cs;
    logic [IDX_W-1:0]  dec_idx;
    logic [WAIT_W-1:0] dec_wait;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dec_cs  = '0;
        dec_idx = '0;
        // Walk from the top index down so the lowest match is written last.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (match[i]) begin
                dec_cs  = NREG'(1) << i;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign dec_wait = wait_tab[dec_idx];

    // ------------------------------------------------------------------
    // Bus-cycle FSM with registered outputs.
    // ------------------------------------------------------------------
    bus_state_t        state;
    logic [WAIT_W-1:0] counter;
    logic [WAIT_W-1:0] wait_q;   // wait states of the region selected at ALE
    logic              strobe;

    assign strobe = !RD_N || !WR_N;   // both low counts as one access

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            Address    <= '0;
            cs         <= '0;
            READY      <= 1'b1;
            decode_err <= 1'b0;
            counter    <= '0;
            wait_q     <= '0;
        end else begin
            decode_err <= 1'b0;

            if (ALE) begin
                // ALE aborts whatever cycle is in progress and outranks a
                // strobe arriving on the same edge.
                Address <= AddrIn;
                cs      <= dec_cs;
                wait_q  <= dec_wait;
                READY   <= 1'b1;
                counter <= '0;
                state   <= ADDR;
            end else begin
                unique case (state)
                    IDLE: begin
                        // A strobe without a preceding ALE is ignored.
                    end

                    ADDR: begin
                        if (strobe) begin
                            if (|cs) begin
                                if (wait_q != '0) begin
                                    counter <= wait_q;
                                    READY   <= 1'b0;
                                    state   <= WAIT;
                                end else begin
                                    state   <= DONE;
                                end
                            end else begin
                                // Unmapped: flag it but finish the cycle
                                // with READY high so the CPU moves on.
                                decode_err <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end

                    WAIT: begin
                        // Counter was loaded with W on the strobe edge, so
                        // seeing 1 here means W low cycles have elapsed.
                        if (counter <= WAIT_W'(1)) begin
                            counter <= '0;
                            READY   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            counter <= counter - WAIT_W'(1);
                        end
                    end

                    DONE: begin
                        if (!strobe) begin
                            cs    <= '0;
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_select_waitgen.sv
`timescale 1ns/1ps
module tb_bus_select_waitgen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ALE;
    logic        IOM;
    logic [19:0] AddrIn;
    logic        RD_N;
    logic        WR_N;
    logic [19:0] Address;
    logic [3:0]  cs;
    logic        READY;
    logic        decode_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference region table, region 0 first.
    int unsigned m_base  [4] = '{32'h00000, 32'h80000, 32'h0FF00, 32'h01C00};
    int unsigned m_limit [4] = '{32'h7FFFF, 32'hFFFFF, 32'h0FF0F, 32'h01DFF};
    bit          m_io    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          m_wait  [4] = '{0, 2, 1, 3};

    bus_select_waitgen dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALE        (ALE),
        .IOM        (IOM),
        .AddrIn     (AddrIn),
        .RD_N       (RD_N),
        .WR_N       (WR_N),
        .Address    (Address),
        .cs         (cs),
        .READY      (READY),
        .decode_err (decode_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Region the address belongs to, or -1 if unmapped.
    function automatic int model_region(input logic [19:0] a, input logic io);
        int unsigned ea;
        for (int i = 0; i < 4; i++) begin
            ea = m_io[i] ? (int'(a) % 65536) : int'(a);
            if (m_io[i] == io && ea >= m_base[i] && ea <= m_limit[i])
                return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full access: ALE, strobe (kind 0 read, 1 write, 2 both), release.
    task automatic do_access(input logic [19:0] a, input logic io, input int kind,
                             input string tag);
        int         r;
        int         w;
        int         low;
        logic [3:0] ecs;
        r   = model_region(a, io);
        w   = (r >= 0) ? m_wait[r] : 0;
        ecs = (r >= 0) ? 4'(1 << r) : 4'b0000;

        ALE = 1'b1; AddrIn = a; IOM = io;
        tick();
        ALE = 1'b0;
        n_cmp++; if (Address !== a) begin n_err++; $display("FAIL %s addr: got %h want %h", tag, Address, a); end
        n_cmp++; if (cs !== ecs) begin n_err++; $display("FAIL %s cs_latch: got %b want %b", tag, cs, ecs); end
        n_cmp++; if (READY !== 1'b1) begin n_err++; $display("FAIL %s ready_addr: got %b want 1", tag, READY); end

        RD_N = (kind == 1) ? 1'b1 : 1'b0;
        WR_N = (kind == 0) ? 1'b1 : 1'b0;
        tick();
        n_cmp++; if (decode_err !== (r < 0)) begin n_err++; $display("FAIL %s derr: got %b want %b", tag, decode_err, (r < 0)); end

        low = 0;
        while (READY === 1'b0 && low < 40) begin
            low++;
            tick();
        end
        n_cmp++; if (low != w) begin n_err++; $display("FAIL %s wait_cycles: got %0d want %0d", tag, low, w); end
        if (low == 0) tick();
        n_cmp++; if (decode_err !== 1'b0) begin n_err++; $display("FAIL %s derr_pulse: got %b want 0", tag, decode_err); end
        n_cmp++; if (READY !== 1'b1) begin n_err++; $display("FAIL %s ready_done: got %b want 1", tag, READY); end
        n_cmp++; if (cs !== ecs) begin n_err++; $display("FAIL %s cs_hold: got %b want %b", tag, cs, ecs); end

        RD_N = 1'b1; WR_N = 1'b1;
        tick();
        n_cmp++; if (cs !== 4'b0000) begin n_err++; $display("FAIL %s cs_release: got %b want 0000", tag, cs); end
    endtask

    task automatic test_reset();
        RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; AddrIn = 20'hABCDE; RD_N = 1'b1; WR_N = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        n_cmp++; if (Address !== 20'h0) begin n_err++; $display("FAIL reset addr: got %h want 00000", Address); end
        n_cmp++; if (cs !== 4'b0) begin n_err++; $display("FAIL reset cs: got %b want 0000", cs); end
        n_cmp++; if (READY !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", READY); end
        n_cmp++; if (decode_err !== 1'b0) begin n_err++; $display("FAIL reset derr: got %b want 0", decode_err); end
    endtask

    task automatic test_idle_strobe();
        RD_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (cs !== 4'b0 || READY !== 1'b1 || decode_err !== 1'b0) begin
                n_err++; $display("FAIL idle_strobe: got cs=%b rdy=%b err=%b want 0000/1/0", cs, READY, decode_err);
            end
        end
        RD_N = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        do_access(20'h12345, 1'b0, 0, "mem_rd_r0");
        do_access(20'h9ABCD, 1'b0, 1, "mem_wr_r1");
        do_access(20'h51C10, 1'b1, 0, "io_rd_r3");
        do_access(20'h0FF05, 1'b1, 0, "io_rd_r2");
        do_access(20'h12345, 1'b0, 2, "both_strobes");
    endtask

    task automatic test_unmapped();
        do_access(20'h00200, 1'b1, 0, "unmapped_io");
        // FSM is back in IDLE: a bare strobe raises nothing.
        RD_N = 1'b0;
        tick();
        n_cmp++; if (decode_err !== 1'b0 || cs !== 4'b0) begin
            n_err++; $display("FAIL unmapped_idle: got err=%b cs=%b want 0/0000", decode_err, cs);
        end
        RD_N = 1'b1;
        tick();
    endtask

    task automatic test_ale_abort();
        ALE = 1'b1; AddrIn = 20'h51C10; IOM = 1'b1;
        tick();
        ALE = 1'b0; RD_N = 1'b0;
        tick();
        n_cmp++; if (READY !== 1'b0) begin n_err++; $display("FAIL abort wait1: got %b want 0", READY); end
        tick();
        n_cmp++; if (READY !== 1'b0) begin n_err++; $display("FAIL abort wait2: got %b want 0", READY); end
        ALE = 1'b1; AddrIn = 20'h00010; IOM = 1'b0;
        tick();
        ALE = 1'b0;
        n_cmp++; if (READY !== 1'b1) begin n_err++; $display("FAIL abort ready: got %b want 1", READY); end
        n_cmp++; if (cs !== 4'b0001) begin n_err++; $display("FAIL abort cs: got %b want 0001", cs); end
        n_cmp++; if (Address !== 20'h00010) begin n_err++; $display("FAIL abort addr: got %h want 00010", Address); end
        tick();  // strobe still low: region 0, no waits
        n_cmp++; if (READY !== 1'b1 || decode_err !== 1'b0) begin
            n_err++; $display("FAIL abort finish: got rdy=%b err=%b want 1/0", READY, decode_err);
        end
        RD_N = 1'b1;
        tick();
        n_cmp++; if (cs !== 4'b0) begin n_err++; $display("FAIL abort release: got %b want 0000", cs); end
    endtask

    task automatic test_reset_mid();
        ALE = 1'b1; AddrIn = 20'h9ABCD; IOM = 1'b0;
        tick();
        ALE = 1'b0; WR_N = 1'b0;
        tick();
        n_cmp++; if (READY !== 1'b0) begin n_err++; $display("FAIL rstmid wait: got %b want 0", READY); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0; WR_N = 1'b1;
        n_cmp++; if (cs !== 4'b0 || READY !== 1'b1 || Address !== 20'h0) begin
            n_err++; $display("FAIL rstmid state: got cs=%b rdy=%b addr=%h want 0000/1/00000", cs, READY, Address);
        end
        tick();
    endtask

    task automatic test_random();
        logic [19:0] a;
        logic        io;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = 20'($urandom); io = 1'($urandom); end
                1: begin a = {4'($urandom), 16'(16'h1BF0 + $urandom_range(0, 16'h0220))}; io = 1'b1; end
                2: begin a = {4'($urandom), 16'(16'hFEF8 + $urandom_range(0, 16'h0020))}; io = 1'b1; end
                default: begin a = 20'(20'h7FFF0 + $urandom_range(0, 16'h0020)); io = 1'($urandom); end
            endcase
            do_access(a, io, int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_idle_strobe();
        test_directed();
        test_unmapped();
        test_ale_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
